// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// latches the instruction and computes the next PC from jump/branch/zero.
module fetch_unit #(
  parameter int INSTR_W  = 8,
  parameter int PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int JMP_W    = 5,
  parameter int BR_OFF_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] instr_o,
  output logic [2:0]         opcode_o,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_o,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state;
  logic            illegal;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] next_pc;

  assign imem_addr = pc_o;
  assign opcode_o  = instr_o[INSTR_W-1 -: 3];
  assign illegal   = (opcode_o == 3'b101) || (opcode_o == 3'b110);
  assign seq_pc    = pc_o + PC_W'(1);

  always_comb begin
    next_pc = seq_pc;
    if (jump)
      next_pc = PC_W'(instr_o[JMP_W-1:0]);
    else if (branch && zero)
      next_pc = seq_pc + PC_W'($signed(instr_o[BR_OFF_W-1:0]));
  end

  // imem_req is its own register so the request only rises on the first
  // edge after reset releases; an ack before that edge is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc_o        <= RESET_PC;
      instr_o     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr_o     <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (illegal) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              pc_o     <= next_pc;
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test of fetch_unit; a negedge monitor checks fetch addresses and
// issued instructions against scoreboard queues filled by the stimulus.
module tb_fetch_unit;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
  } issue_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_ack = 1'b0;
  logic [7:0] instr_o;
  logic [2:0] opcode_o;
  logic       instr_valid;
  logic [7:0] pc_o;
  logic       stall = 1'b0;
  logic       jump = 1'b0;
  logic       branch = 1'b0;
  logic       zero = 1'b0;
  logic       halted;

  int checks = 0;
  int errors = 0;
  logic [7:0] addr_q[$];
  issue_t     issue_q[$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr_o(instr_o), .opcode_o(opcode_o), .instr_valid(instr_valid),
    .pc_o(pc_o), .stall(stall), .jump(jump), .branch(branch), .zero(zero),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch and every valid issue cycle pops one entry.
  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      if (addr_q.size() == 0) check_output("unexpected_fetch", {24'd0, imem_addr}, 32'hFFFF);
      else check_output("imem_addr", {24'd0, imem_addr}, {24'd0, addr_q.pop_front()});
    end
    if (instr_valid) begin
      if (issue_q.size() == 0) begin
        check_output("unexpected_issue", {24'd0, instr_o}, 32'hFFFF);
      end else begin
        issue_t e;
        e = issue_q.pop_front();
        check_output("issue_pc", {24'd0, pc_o}, {24'd0, e.pc});
        check_output("issue_instr", {24'd0, instr_o}, {24'd0, e.instr});
        check_output("issue_opcode", {29'd0, opcode_o}, {29'd0, e.instr[7:5]});
      end
    end
  end

  // One fetch/issue: wait for the request, ack after wait_n cycles, then
  // hold ISSUE for stall_n cycles with spurious acks before releasing.
  task automatic apply_stimulus(input logic [7:0] data, input int wait_n, input logic [7:0] exp_pc,
                                input logic j, input logic b, input logic z, input int stall_n);
    int n = 0;
    while (!imem_req && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("req_raised", {31'd0, imem_req}, 32'd1);
    addr_q.push_back(exp_pc);
    for (int i = 0; i < wait_n; i++) begin
      @(posedge clk); #1;
      check_output("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    for (int i = 0; i <= stall_n; i++) issue_q.push_back('{pc: exp_pc, instr: data});
    @(posedge clk); #1;
    imem_ack = 1'b0;
    imem_rdata = 8'h99;
    jump = j;
    branch = b;
    zero = z;
    stall = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      imem_ack = 1'b1;
      @(posedge clk); #1;
      check_output("stall_pc_hold", {24'd0, pc_o}, {24'd0, exp_pc});
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_output("rst_halted", {31'd0, halted}, 32'd0);
    check_output("rst_pc", {24'd0, pc_o}, 32'd0);
    check_output("rst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check_output("reset_pc", {24'd0, pc_o}, 32'd0);
    check_output("reset_instr", {24'd0, instr_o}, 32'd0);
    check_output("reset_valid", {31'd0, instr_valid}, 32'd0);
    check_output("reset_halted", {31'd0, halted}, 32'd0);
    check_output("reset_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_output("req_before_edge", {31'd0, imem_req}, 32'd0);

    apply_stimulus(8'h00, 0, 8'h00, 0, 0, 0, 0);
    apply_stimulus(8'h20, 0, 8'h01, 0, 0, 0, 0);
    apply_stimulus(8'hF4, 0, 8'h02, 1, 1, 1, 0);
    apply_stimulus(8'hF0, 0, 8'h14, 1, 0, 0, 0);
    apply_stimulus(8'h6E, 0, 8'h10, 0, 1, 1, 0);
    apply_stimulus(8'hF0, 0, 8'h0F, 1, 0, 0, 0);
    apply_stimulus(8'h6E, 0, 8'h10, 0, 1, 0, 0);
    apply_stimulus(8'hE0, 0, 8'h11, 1, 0, 0, 0);
    apply_stimulus(8'h6E, 0, 8'h00, 0, 1, 1, 0);
    apply_stimulus(8'h40, 4, 8'hFF, 0, 0, 0, 3);
    apply_stimulus(8'hA0, 0, 8'h00, 0, 0, 0, 0);

    imem_ack = 1'b1;
    imem_rdata = 8'h33;
    for (int i = 0; i < 20; i++) begin
      check_output("halt_state", {15'd0, imem_req, instr_valid, halted, pc_o, instr_o},
                   {15'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA0});
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;

    pulse_reset();
    apply_stimulus(8'hC3, 0, 8'h00, 0, 0, 0, 0);
    check_output("halt_op110", {31'd0, halted}, 32'd1);
    check_output("halt_op110_pc", {24'd0, pc_o}, 32'd0);

    pulse_reset();
    @(posedge clk); #1;
    check_output("req_after_reset", {31'd0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("req_drop_midfetch", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 8'h55;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_output("late_ack_instr", {24'd0, instr_o}, 32'd0);
    check_output("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    apply_stimulus(8'h20, 1, 8'h00, 0, 0, 0, 0);

    @(negedge clk);
    check_output("addr_q_empty", addr_q.size(), 32'd0);
    check_output("issue_q_empty", issue_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
